// File: rtl/i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// i2s_audio_tx
//
// I2S serializer for the external DAC. A one-deep holding buffer accepts a
// stereo PCM sample; at the start of each frame the buffer (or, if it is
// empty, the previous frame) is loaded into the frame shift source and sent
// MSB first, left channel then right channel. All logic runs on clk_p.
//
// Ports:
//   clk_p         pixel clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   l_data        left sample (two's complement, passed through unchanged)
//   r_data        right sample
//   sample_valid  l_data/r_data valid this cycle
//   sample_ready  holding buffer empty
//   i2s_bclk      bit clock, period 2*BCLK_HALF clk_p cycles
//   i2s_lrck      word select, 0 = left, 1 = right (leads MSB by one BCLK)
//   i2s_din       serial data, changes with the falling edge of i2s_bclk
//   underrun      one-cycle pulse when a frame is loaded with no new sample
//   underrun_cnt  saturating count of underrun pulses
//
// Handshake: a transfer happens on a rising clk_p edge where
// sample_valid & sample_ready are both 1. sample_ready is the registered
// inverse of the buffer-full flag, so it never depends on sample_valid in
// the same cycle. While sample_ready is 0 the source must keep its data
// and sample_valid stable; nothing is captured.
// ---------------------------------------------------------------------------
module i2s_audio_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk_p,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] l_data,
  input  logic [SAMPLE_W-1:0] r_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_din,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int DIV_W   = $clog2(BCLK_HALF);
  localparam int SLOT_W  = $clog2(FRAME_W);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [FRAME_W-1:0]  last_q, last_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic                din_q, din_d;
  logic                lrck_q, lrck_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          underrun_cnt_q, underrun_cnt_d;

  logic                div_tc;
  logic                fall_evt;
  logic                slot_wrap;
  logic [SLOT_W-1:0]   bit_idx;

  assign div_tc    = (div_cnt_q == DIV_W'(BCLK_HALF - 1));
  // bclk is about to go 1->0: this is the only moment slot/outputs advance.
  assign fall_evt  = div_tc & bclk_q;
  assign slot_wrap = (slot_q == SLOT_W'(FRAME_W - 1));

  always_comb begin
    div_cnt_d      = div_tc ? '0 : div_cnt_q + 1'b1;
    bclk_d         = div_tc ? ~bclk_q : bclk_q;
    slot_d         = slot_q;
    frame_d        = frame_q;
    last_d         = last_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    hold_full_d    = hold_full_q;
    din_d          = din_q;
    lrck_d         = lrck_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    bit_idx        = '0;

    if (fall_evt) begin
      slot_d = slot_wrap ? '0 : slot_q + 1'b1;
      if (slot_wrap) begin
        // Frame boundary: the load looks at the buffer state before any
        // transfer in this same cycle, so a simultaneous transfer lands in
        // the buffer and plays on the following frame.
        if (hold_full_q) begin
          frame_d     = {hold_l_q, hold_r_q};
          last_d      = {hold_l_q, hold_r_q};
          hold_full_d = 1'b0;
        end else begin
          frame_d    = last_q;
          underrun_d = 1'b1;
          if (underrun_cnt_q != 8'hFF) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
          end
        end
      end
      // Slot 0 carries frame bit FRAME_W-1 (left MSB).
      bit_idx = SLOT_W'(FRAME_W - 1) - slot_d;
      din_d   = frame_d[bit_idx];
      // Word select switches one slot ahead of the channel's MSB.
      lrck_d  = (slot_d >= SLOT_W'(SAMPLE_W - 1)) &&
                (slot_d <= SLOT_W'(FRAME_W - 2));
    end

    // Capture is gated by the registered flag only; a load that empties
    // the buffer this cycle does not open it until the next cycle.
    if (sample_valid && !hold_full_q) begin
      hold_l_d    = l_data;
      hold_r_d    = r_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      div_cnt_q      <= '0;
      bclk_q         <= 1'b0;
      slot_q         <= SLOT_W'(FRAME_W - 1);
      frame_q        <= '0;
      last_q         <= '0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      hold_full_q    <= 1'b0;
      din_q          <= 1'b0;
      lrck_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      bclk_q         <= bclk_d;
      slot_q         <= slot_d;
      frame_q        <= frame_d;
      last_q         <= last_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      hold_full_q    <= hold_full_d;
      din_q          <= din_d;
      lrck_q         <= lrck_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_din      = din_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_tx
//
// dut  : BCLK_HALF=8 instance; frames reassembled from the serial stream on
//        rising bclk and compared against exp_q, lrck checked per slot.
// dut2 : BCLK_HALF=2 instance; bit-clock period, sample consumption rate and
//        underrun counter saturation.
// ---------------------------------------------------------------------------
module tb_i2s_audio_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [15:0] l_data = '0, r_data = '0;
  logic        valid = 1'b0;
  logic        ready, bclk, lrck, din, ur;
  logic [7:0]  ucnt;

  logic        reset2 = 1'b0;
  logic [15:0] l2 = '0, r2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, bclk2, lrck2, din2, ur2;
  logic [7:0]  ucnt2;

  i2s_audio_tx #(.BCLK_HALF(8), .SAMPLE_W(16)) dut (
    .clk_p(clk), .reset(reset), .l_data(l_data), .r_data(r_data),
    .sample_valid(valid), .sample_ready(ready), .i2s_bclk(bclk),
    .i2s_lrck(lrck), .i2s_din(din), .underrun(ur), .underrun_cnt(ucnt)
  );

  i2s_audio_tx #(.BCLK_HALF(2), .SAMPLE_W(16)) dut2 (
    .clk_p(clk), .reset(reset2), .l_data(l2), .r_data(r2),
    .sample_valid(valid2), .sample_ready(ready2), .i2s_bclk(bclk2),
    .i2s_lrck(lrck2), .i2s_din(din2), .underrun(ur2), .underrun_cnt(ucnt2)
  );

  // cycle counters: value k after the k-th rising edge since reset release
  int cyc, cyc2;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk or posedge reset2)
    if (reset2) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  int ur2_pulses;
  always @(posedge clk or posedge reset2)
    if (reset2) ur2_pulses <= 0; else if (ur2) ur2_pulses <= ur2_pulses + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor, dut ----------------
  int          rx_slot;
  int          last_rise;
  int          first_fall;
  bit          started;
  logic        bclk_prev, ur_prev;
  logic [31:0] rx_frame;

  initial begin : monitor
    logic [31:0] e;
    rx_slot = 31; last_rise = -1; first_fall = -1; started = 0;
    bclk_prev = 0; ur_prev = 0; rx_frame = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_slot = 31; last_rise = -1; first_fall = -1; started = 0;
      end else begin
        if (bclk && !bclk_prev) begin
          check("lrck_slot", lrck, (rx_slot >= 15 && rx_slot <= 30));
          if (last_rise >= 0) check("bclk_period", cyc - last_rise, 16);
          last_rise = cyc;
          rx_frame[31 - rx_slot] = din;
          if (rx_slot == 31 && started && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame", rx_frame, e);
          end
        end
        if (!bclk && bclk_prev) begin
          rx_slot = (rx_slot + 1) % 32;
          if (rx_slot == 0) started = 1;
          if (first_fall < 0) first_fall = cyc;
        end
        if (ur) begin
          check("underrun_at_load", {bclk_prev, bclk, (rx_slot == 0)}, 3'b101);
          check("underrun_one_cycle", ur_prev, 1'b0);
        end
      end
      bclk_prev = bclk;
      ur_prev   = ur;
    end
  end

  // ---------------- monitor, dut2 (bclk period) ----------------
  int   rise2_n, last_rise2, period2;
  logic prev2;
  initial begin : monitor2
    rise2_n = 0; last_rise2 = -1; period2 = 0; prev2 = 0;
    forever begin
      @(negedge clk);
      if (reset2) begin
        rise2_n = 0; last_rise2 = -1;
      end else if (bclk2 && !prev2) begin
        if (last_rise2 >= 0) period2 = cyc2 - last_rise2;
        last_rise2 = cyc2;
        rise2_n++;
      end
      prev2 = bclk2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_reset2();
    @(negedge clk);
    reset2 = 1'b1; valid2 = 1'b0;
    repeat (3) @(negedge clk);
    reset2 = 1'b0;
  endtask

  // returns the clk count of the rising edge that performs the transfer
  task automatic send(input logic [15:0] l, input logic [15:0] r,
                      output int acc_cyc);
    int w;
    @(negedge clk);
    valid = 1'b1; l_data = l; r_data = r; w = 0;
    while (!ready && w < 2000) begin @(negedge clk); w++; end
    if (!ready) check("send_ready_timeout", ready, 1'b1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] l, input logic [15:0] r,
                       output int acc_cyc);
    int w;
    @(negedge clk);
    valid2 = 1'b1; l2 = l; r2 = r; w = 0;
    while (!ready2 && w < 2000) begin @(negedge clk); w++; end
    if (!ready2) check("send2_ready_timeout", ready2, 1'b1);
    acc_cyc = cyc2 + 1;
    @(posedge clk); #1;
    valid2 = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < max_cyc) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int a1, a2, w;
    int acc[10];
    #1 reset2 = 1'b1;

    // Reset state and idle stream: silent frames, underrun on every load
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrck", lrck, 1'b0);
    check("rst_din", din, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_underrun", ur, 1'b0);
    check("rst_ucnt", ucnt, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h0000_0000);
    wait_drain(2000);
    check("idle_ucnt_1", ucnt, 8'd1);
    exp_q.push_back(32'h0000_0000);
    wait_drain(2000);
    check("idle_ucnt_2", ucnt, 8'd2);

    // One sample before the first load
    do_reset();
    send(16'hA5C3, 16'h3C5A, a1);
    exp_q.push_back(32'hA5C3_3C5A);
    wait_drain(2000);
    check("first_frame_ucnt", ucnt, 8'd0);

    // Back-to-back samples: second held off until the first load
    do_reset();
    send(16'h8001, 16'h7FFE, a1);
    check("ready_drop", ready, 1'b0);
    send(16'hFFFF, 16'h0000, a2);
    check("second_accept_cyc", a2, 17);
    exp_q.push_back(32'h8001_7FFE);
    exp_q.push_back(32'hFFFF_0000);
    exp_q.push_back(32'hFFFF_0000);
    wait_drain(4000);
    check("b2b_ucnt", ucnt, 8'd1);

    // Starved source: last frame repeats
    do_reset();
    send(16'h1234, 16'h5678, a1);
    repeat (3) exp_q.push_back(32'h1234_5678);
    wait_drain(4000);
    check("repeat_ucnt", ucnt, 8'd2);

    // Reset in the middle of slot 20
    w = 0;
    while (rx_slot != 20 && w < 2000) begin @(negedge clk); w++; end
    check("reach_slot20", rx_slot, 20);
    check("pre_reset_lrck", lrck, 1'b1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_bclk", bclk, 1'b0);
    check("mid_rst_lrck", lrck, 1'b0);
    check("mid_rst_din", din, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_underrun", ur, 1'b0);
    check("mid_rst_ucnt", ucnt, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h0000_0000);
    w = 0;
    while (first_fall < 0 && w < 100) begin @(negedge clk); w++; end
    check("first_fall_cyc", first_fall, 16);
    wait_drain(2000);
    check("post_rst_ucnt", ucnt, 8'd1);

    // BCLK_HALF=2: period, sustained feed, saturation
    do_reset2();
    w = 0;
    while (rise2_n < 3 && w < 100) begin @(negedge clk); w++; end
    check("bclk2_period", period2, 4);

    do_reset2();
    for (int i = 0; i < 10; i++) begin
      send2(16'h1000 + 16'(i), 16'h2000 + 16'(i), acc[i]);
    end
    check("feed2_second_accept", acc[1], 5);
    for (int i = 2; i < 10; i++) check("feed2_interval", acc[i] - acc[i-1], 128);
    check("feed2_no_underrun", ur2_pulses, 0);
    check("feed2_ucnt", ucnt2, 8'd0);

    w = 0;
    while (ur2_pulses != 254 && w < 40000) begin @(negedge clk); w++; end
    check("ucnt2_at_254", ucnt2, 8'd254);
    w = 0;
    while (ur2_pulses != 300 && w < 10000) begin @(negedge clk); w++; end
    check("ur2_pulses_300", ur2_pulses, 300);
    check("ucnt2_saturated", ucnt2, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- I2S serializer that sits downstream of the guest audio mixer on the Tang Nano 20K board.
- Accepts 16-bit left/right PCM samples through a valid/ready handshake into a one-deep holding buffer.
- Drives BCLK, LRCK and DIN to the external I2S DAC in the pixel-clock domain (25.2 MHz). Replaces the free-running audio_top path.
- Repeats the last frame on underrun and counts underruns.

Parameters:
BCLK_HALF, 8, clk_p cycles per BCLK half-period (>=2); default gives BCLK 1.575 MHz, fs 49.22 kHz
SAMPLE_W, 16, bits per channel; frame = 2*SAMPLE_W BCLK slots

Ports:
clk_p  input  1  pixel clock (25.2 MHz); all logic on rising edge
reset  input  1  asynchronous, active-high reset
l_data  input  SAMPLE_W  left sample, two's complement
r_data  input  SAMPLE_W  right sample, two's complement
sample_valid  input  1  l_data/r_data valid this cycle
sample_ready  output  1  holding buffer empty; transfer when valid&ready
i2s_bclk  output  1  bit clock to DAC
i2s_lrck  output  1  word select; 0 = left, 1 = right
i2s_din  output  1  serial data, MSB first
underrun  output  1  one-cycle pulse: frame loaded with holding buffer empty
underrun_cnt  output  8  saturating underrun count

Behaviour:
- Reset (async, any time, incl. mid-frame):
  - div_cnt=0, bclk=0, lrck=0, din=0.
  - slot=2*SAMPLE_W-1, frame register=0, last frame=0.
  - hold_full=0, so sample_ready=1.
  - underrun=0, underrun_cnt=0.
  - Release starts cleanly; no partial frame is emitted.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 and wraps to 0.
  - At terminal count, bclk toggles. A 1->0 toggle is a "falling event".
  - First falling event occurs 2*BCLK_HALF cycles after reset release.
- Slot counter: on each falling event, slot increments modulo 2*SAMPLE_W. Let N=SAMPLE_W.
- Frame load: on the falling event entering slot 0:
  - If hold_full: frame <= {hold_L, hold_R}, last <= same value, hold_full <= 0.
  - Else: frame <= last, underrun pulses for 1 cycle, underrun_cnt increments and saturates at 255.
- Outputs: registered, updated in the same cycle bclk goes low.
  - din = frame bit (2N-1-slot), i.e. left MSB in slot 0 and right LSB in slot 2N-1.
  - lrck = 1 for slots N-1..2N-2, else 0. LRCK therefore leads the channel MSB by one BCLK (standard I2S).
  - The DAC samples on the rising bclk edge, BCLK_HALF cycles after the output update.
- Handshake:
  - sample_ready = ~hold_full (registered state, no combinational path from valid).
  - valid&ready captures l_data/r_data and sets hold_full next cycle.
  - While ready=0, valid is ignored; the data is not lost, and the source must hold it.
- Simultaneous transfer and frame load with hold empty: the load sees the empty buffer (underrun, repeat last). The new sample is captured into hold and plays next frame.
- Simultaneous frame load with hold_full and valid asserted: ready=0 that cycle, so there is no capture. ready=1 the following cycle.
- Width: no arithmetic on samples; bits pass unchanged.

Test Plan:
- Reset, no samples → bclk period 16 cycles; lrck low slots 31,0..14 and high 15..30; din=0; underrun pulses at every slot-0 entry; underrun_cnt=1 after the first frame.
- Push L=16'hA5C3, R=16'h3C5A before the first falling event → slots 0..15 carry A5C3 MSB first, 16..31 carry 3C5A; lrck rises with the slot-15 update; no underrun.
- Push two samples back-to-back → first accepted (ready drops the next cycle); second held off until the next slot-0 load; ready returns 1 the cycle after the load.
- Stop feeding after 0x1234/0x5678 → frame repeats identically; underrun_cnt increments per frame and saturates at 255 after 300 starved frames.
- Assert reset mid-slot 20 → all outputs 0 and sample_ready=1 immediately; after release, the first falling event is 16 cycles later and enters slot 0.
- BCLK_HALF=2, continuous valid → bclk period 4 cycles; one sample consumed per 128 cycles; no underrun.
